// File: rtl/ptl_rx_pulse_monitor.sv
// ptl_rx_pulse_monitor: receiver stage behind a PTL transmitter that toggles the line once per
// SFQ pulse. The line is synchronised into clk, and each transition becomes a one-cycle pulse.
// Transitions are ignored during a startup blanking window. Spacing between accepted
// transitions is checked against MIN_GAP, and pulses and violations are counted.
//
// Ports:
//   clk       - system clock, all state on the rising edge
//   rst_n     - asynchronous active-low reset
//   a_line    - asynchronous toggle-encoded line from the transmitter
//   clr       - synchronous clear of both counters and the sticky violation flag
//   q_pulse   - registered one-cycle pulse per accepted line transition
//   ready     - high once startup blanking has finished
//   viol      - sticky flag, set when two transitions are closer than MIN_GAP cycles
//   pulse_cnt - accepted-transition count (wraps)
//   viol_cnt  - spacing-violation count (saturates at all-ones)
module ptl_rx_pulse_monitor #(
  parameter int unsigned INIT_CYCLES = 8,
  parameter int unsigned MIN_GAP     = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_line,
  input  logic             clr,
  output logic             q_pulse,
  output logic             ready,
  output logic             viol,
  output logic [CNT_W-1:0] pulse_cnt,
  output logic [CNT_W-1:0] viol_cnt
);

  typedef enum logic [1:0] {StInit, StReady, StGuard} state_e;

  localparam logic [7:0]       InitLoad = 8'(INIT_CYCLES);
  localparam logic [7:0]       GapLoad  = 8'(MIN_GAP - 1);
  localparam logic [CNT_W-1:0] CntMax   = '1;
  localparam logic [CNT_W-1:0] CntOne   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             s1_q, s2_q, prev_q;
  logic             edge_det;
  state_e           state_q, state_d;
  logic [7:0]       timer_q, timer_d;
  logic             q_pulse_q, q_pulse_d;
  logic             ready_q, ready_d;
  logic             viol_q, viol_d;
  logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [CNT_W-1:0] viol_cnt_q, viol_cnt_d;
  logic             accept, violation;

  // prev tracks s2 in every state, so no stale edge is left over when blanking ends.
  assign edge_det = s2_q ^ prev_q;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    ready_d     = ready_q;
    viol_d      = viol_q;
    pulse_cnt_d = pulse_cnt_q;
    viol_cnt_d  = viol_cnt_q;
    accept      = 1'b0;
    violation   = 1'b0;

    case (state_q)
      StInit: begin
        if (timer_q == 8'd0) begin
          state_d = StReady;
          ready_d = 1'b1;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      StReady: begin
        if (edge_det) begin
          accept = 1'b1;
          if (MIN_GAP > 1) begin
            state_d = StGuard;
            timer_d = GapLoad;
          end
        end
      end
      StGuard: begin
        if (edge_det) begin
          accept    = 1'b1;
          violation = 1'b1;
          timer_d   = GapLoad;
        end else if (timer_q <= 8'd1) begin
          // The guard window closes on the cycle the timer would reach zero.
          state_d = StReady;
          timer_d = 8'd0;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      default: state_d = StInit;
    endcase

    q_pulse_d = accept;

    // clr wins over a same-cycle increment; the pulse itself still goes out.
    if (clr) begin
      pulse_cnt_d = '0;
      viol_cnt_d  = '0;
      viol_d      = 1'b0;
    end else begin
      if (accept) pulse_cnt_d = pulse_cnt_q + CntOne;
      if (violation) begin
        viol_d = 1'b1;
        if (viol_cnt_q != CntMax) viol_cnt_d = viol_cnt_q + CntOne;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      prev_q      <= 1'b0;
      state_q     <= StInit;
      timer_q     <= InitLoad;
      q_pulse_q   <= 1'b0;
      ready_q     <= 1'b0;
      viol_q      <= 1'b0;
      pulse_cnt_q <= '0;
      viol_cnt_q  <= '0;
    end else begin
      s1_q        <= a_line;
      s2_q        <= s1_q;
      prev_q      <= s2_q;
      state_q     <= state_d;
      timer_q     <= timer_d;
      q_pulse_q   <= q_pulse_d;
      ready_q     <= ready_d;
      viol_q      <= viol_d;
      pulse_cnt_q <= pulse_cnt_d;
      viol_cnt_q  <= viol_cnt_d;
    end
  end

  assign q_pulse   = q_pulse_q;
  assign ready     = ready_q;
  assign viol      = viol_q;
  assign pulse_cnt = pulse_cnt_q;
  assign viol_cnt  = viol_cnt_q;

endmodule
